// File: rtl/neuron_mac_act.sv
// rtl/neuron_mac_act.sv - Q4.12 multiply-accumulate with saturation feeding a registered tanh LUT
module neuron_mac_act #(
  parameter int ACC_W     = 32,
  parameter int MAX_TERMS = 256,
  parameter int CNT_W     = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_w,
  input  logic        in_last,
  input  logic [15:0] bias,
  output logic [7:0]  lut_addr,
  input  logic [15:0] lut_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [15:0] out_pre,
  output logic        out_sat,
  output logic        out_trunc
);

  typedef enum logic [1:0] {
    S_ACC   = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Q4.12 range limits expressed at accumulator width
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-15){1'b0}}, 15'h7fff};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-15){1'b1}}, 15'h0000};

  state_t                  state;
  state_t                  state_next;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [31:0]      prod;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    beat;
  logic                    last_beat;
  logic                    ovf_hi;
  logic                    ovf_lo;
  logic [15:0]             sat;
  logic                    out_fire;

  assign in_ready = (state == S_ACC);
  assign beat     = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Q8.24 product back to Q.12 by arithmetic shift, then sign-extended to accumulator width
  assign prod     = $signed(in_x) * $signed(in_w);
  assign term     = ACC_W'(prod >>> 12);
  assign acc_base = (cnt == '0) ? ACC_W'($signed(bias)) : acc;
  assign acc_next = acc_base + term;

  assign cnt_inc   = cnt + CNT_W'(1);
  assign last_beat = in_last || (cnt_inc == CNT_W'(MAX_TERMS));

  assign ovf_hi = (acc_next > SAT_MAX);
  assign ovf_lo = (acc_next < SAT_MIN);
  assign sat    = ovf_hi ? 16'h7fff : (ovf_lo ? 16'h8000 : acc_next[15:0]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_ACC;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: accumulate, give the LUT one edge to read, capture, then hold until accepted
  always_comb begin
    state_next = state;
    case (state)
      S_ACC:   if (beat && last_beat) state_next = S_ISSUE;
      S_ISSUE: state_next = S_CAPT;
      S_CAPT:  state_next = S_OUT;
      S_OUT:   if (out_fire) state_next = S_ACC;
      default: state_next = S_ACC;
    endcase
  end

  // Accumulator, term counter, LUT address and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      lut_addr  <= 8'h80;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_pre   <= 16'h0000;
      out_sat   <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      if (beat) begin
        acc <= acc_next;
        cnt <= last_beat ? '0 : cnt_inc;
        if (last_beat) begin
          out_pre   <= sat;
          out_sat   <= ovf_hi || ovf_lo;
          out_trunc <= !in_last;
          lut_addr  <= {~sat[15], sat[14:8]};
        end
      end
      if (state == S_CAPT) begin
        out_data  <= lut_data;
        out_valid <= 1'b1;
      end
      if ((state == S_OUT) && out_fire) begin
        out_valid <= 1'b0;
        acc       <= '0;
      end
    end
  end

endmodule

// File: doc/neuron_mac_act.md
Name: neuron_mac_act

Overview:
- Per-neuron multiply-accumulate stage sitting directly upstream of the tanh activation LUT.
- Consumes a stream of (input, weight) Q4.12 pairs plus a bias, and accumulates their dot product in a wide register.
- Saturates the sum to Q4.12, drives the LUT address, captures the LUT's registered tanh value, and presents it on a valid/ready output.

Parameters:
- ACC_W, 32, accumulator width in bits. Must be ≥ 20 + clog2(MAX_TERMS).
- MAX_TERMS, 256, maximum beats per vector. The beat that reaches this count is treated as last.
- CNT_W, 9, term counter width. Must be ≥ clog2(MAX_TERMS+1).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  beat valid
- in_ready  out  1  beat accept
- in_x  in  16  signed Q4.12 activation
- in_w  in  16  signed Q4.12 weight
- in_last  in  1  final beat of vector
- bias  in  16  signed Q4.12, sampled on first beat of vector
- lut_addr  out  8  address to tanh LUT (registered)
- lut_data  in  16  Q4.12 tanh from LUT, valid one edge after lut_addr
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  16  Q4.12 tanh result
- out_pre  out  16  saturated Q4.12 pre-activation
- out_sat  out  1  pre-activation was clipped
- out_trunc  out  1  vector ended by MAX_TERMS, not in_last

Behaviour:
- Reset (rst_n low, async): state=ACC, acc=0, cnt=0, lut_addr=0x80, out_valid=0, out_data=0, out_pre=0, out_sat=0, out_trunc=0.
- in_ready=1 only in state ACC. A beat is accepted when in_valid && in_ready.
- Product: p = in_x*in_w as signed 32-bit Q8.24. Term = p >>> 12 (arithmetic, truncating), sign-extended to ACC_W.
- Accepted beat with cnt==0: acc_next = sext(bias) + term. Otherwise acc_next = acc + term.
- cnt increments on every accepted beat.
- Last beat = in_last || (cnt+1 == MAX_TERMS). On the last beat, in the same edge:
  - sat = clamp(acc_next, -32768, 32767); out_pre <= sat.
  - out_sat <= (acc_next outside that range).
  - out_trunc <= !in_last.
  - lut_addr <= {~sat[15], sat[14:8]}, so -8.0 maps to 0x00, 0.0 to 0x80, +7.9375 to 0xFF.
  - cnt <= 0; state <= ISSUE.
- ISSUE (1 cycle): lut_addr held stable while the LUT samples it; state <= CAPT.
- CAPT (1 cycle): out_data <= lut_data; out_valid <= 1; state <= OUT.
- OUT: out_data, out_pre, out_sat and out_trunc are held stable while out_valid && !out_ready. On out_valid && out_ready: out_valid <= 0, acc <= 0, state <= ACC. in_ready rises the following cycle.
- Latency: out_valid asserts exactly 2 clock edges after the edge accepting the last beat.
- Throughput: one beat/cycle while accumulating; 3 idle cycles minimum between vectors.
- in_valid is ignored outside ACC; no beats are dropped because in_ready=0 there.
- lut_addr changes only on the last-beat edge and on reset.
- Asserting reset mid-vector or mid-output discards all partial state; the first accepted beat after release is treated as a first beat (bias sampled).
- Single-beat vector (in_last on first beat) is legal.
- Unused state encodings return to ACC.

Test Plan:
- Single beat x=0x1000 (1.0), w=0x1000, bias=0, in_last=1 -> lut_addr=0x90, out_pre=0x1000, out_sat=0; out_valid 2 edges later with out_data=LUT[0x90].
- bias=0xF800 (-0.5), one beat x=0x0400 (0.25), w=0x2000 (2.0) -> out_pre=0x0000, lut_addr=0x80.
- Four beats x=w=0x4000 (4.0) -> out_pre=0x7FFF, lut_addr=0xFF, out_sat=1. Repeating with w=0xC000 -> out_pre=0x8000, lut_addr=0x00, out_sat=1.
- MAX_TERMS=4, six beats without in_last -> 4th beat ends the vector with out_trunc=1. Beats 5-6 are held off by in_ready=0 and form the next vector's first two beats.
- out_ready held low 5 cycles after out_valid -> out_data and out_pre stable, in_ready=0 throughout; handshake, then in_ready=1 next cycle.
- rst_n pulsed low after 3 of 5 beats -> all outputs return to reset values immediately. A new 1-beat vector then yields a result independent of the aborted beats.
